// File: rtl/epu_tr_pkg.sv
// Shared definitions for the transpose engine and the QK^T sequencer:
// transpose FSM state encoding and index-width helpers.
package epu_tr_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_RUN   = 2'd1,
    TR_DRAIN = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_t;

  // Token index width, never narrower than one bit.
  function automatic int tr_t_w(input int t);
    return ($clog2(t) > 1) ? $clog2(t) : 1;
  endfunction

  // Feature index width, never narrower than one bit.
  function automatic int tr_d_w(input int dmax);
    return ($clog2(dmax) > 1) ? $clog2(dmax) : 1;
  endfunction

endpackage

// File: rtl/epu_sram_1r1w.sv
// Simple dual-port word SRAM: one byte-masked write port, one read port
// with a registered output that holds its value between reads.
module epu_sram_1r1w #(
  parameter  int DEPTH  = 8192,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BYTE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BYTE_W-1:0] wmask,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTE_W; i++) begin
        if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kt_transpose_engine.sv
// K -> K^T transpose responder: host loads K into buffer A, a run copies
// A[t][d] into buffer B at [d][t], and the B port serves element reads.
module kt_transpose_engine
  import epu_tr_pkg::*;
#(
  parameter  int T      = 8,
  parameter  int DMAX   = 1024,
  parameter  int DATA_W = 32,
  localparam int T_W    = tr_t_w(T),
  localparam int D_W    = tr_d_w(DMAX),
  localparam int BYTE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       D_len,
  input  logic              k_we,
  input  logic [T_W-1:0]    k_t,
  input  logic [D_W-1:0]    k_d,
  input  logic [DATA_W-1:0] k_wdata,
  input  logic [BYTE_W-1:0] k_wmask,
  input  logic              tr_start,
  output logic              tr_busy,
  output logic              tr_done,
  input  logic              tr_b_re,
  input  logic [31:0]       tr_b_row,
  input  logic [31:0]       tr_b_col,
  output logic [DATA_W-1:0] tr_b_rdata,
  output logic              tr_b_rvalid
);

  localparam int DEPTH  = T * DMAX;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DE_W   = D_W + 1;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [D_W-1:0] d,
                                                input logic [T_W-1:0] t);
    return ADDR_W'(d) * ADDR_W'(T) + ADDR_W'(t);
  endfunction

  function automatic logic [DE_W-1:0] clamp_len(input logic [15:0] len);
    return (32'(len) > DMAX) ? DE_W'(DMAX) : DE_W'(len);
  endfunction

  tr_state_t         state, state_nxt;
  logic              start_acc;
  logic              last_issue;
  logic [DE_W-1:0]   d_eff;
  logic [T_W-1:0]    cnt_t;
  logic [D_W-1:0]    cnt_d;
  logic              vld_p0;
  logic [T_W-1:0]    t_p0;
  logic [D_W-1:0]    d_p0;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              a_we;
  logic              b_hit;
  logic              b_hit_p0;
  logic              rvalid_p0;

  assign last_issue = (state == TR_RUN) && (cnt_t == T_W'(T - 1)) &&
                      ({1'b0, cnt_d} == d_eff - DE_W'(1));

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      TR_IDLE: begin
        if (tr_start) begin
          start_acc = 1'b1;
          state_nxt = (clamp_len(D_len) == '0) ? TR_DONE : TR_RUN;
        end
      end
      TR_RUN:   if (last_issue) state_nxt = TR_DRAIN;
      TR_DRAIN: if (!vld_p0) state_nxt = TR_DONE;
      TR_DONE:  state_nxt = TR_IDLE;
      default:  state_nxt = TR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TR_IDLE;
      d_eff     <= '0;
      cnt_t     <= '0;
      cnt_d     <= '0;
      vld_p0    <= 1'b0;
      rvalid_p0 <= 1'b0;
      b_hit_p0  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        d_eff <= clamp_len(D_len);
        cnt_t <= '0;
        cnt_d <= '0;
      end else if (state == TR_RUN) begin
        if (cnt_t == T_W'(T - 1)) begin
          cnt_t <= '0;
          cnt_d <= cnt_d + D_W'(1);
        end else begin
          cnt_t <= cnt_t + T_W'(1);
        end
      end
      vld_p0    <= (state == TR_RUN);
      rvalid_p0 <= tr_b_re;
      if (tr_b_re) b_hit_p0 <= b_hit;
    end
  end

  // Stage p0: index pair travels with the A read; B write lands next edge
  always_ff @(posedge clk) begin
    if (state == TR_RUN) begin
      t_p0 <= cnt_t;
      d_p0 <= cnt_d;
    end
  end

  assign a_we = k_we && (state == TR_IDLE) &&
                (32'(k_t) < 32'(T)) && (32'(k_d) < 32'(DMAX));

  epu_sram_1r1w #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_a (
    .clk   (clk),
    .we    (a_we),
    .waddr (addr_of(k_d, k_t)),
    .wdata (k_wdata),
    .wmask (k_wmask),
    .re    (state == TR_RUN),
    .raddr (addr_of(cnt_d, cnt_t)),
    .rdata (a_q)
  );

  // Out-of-range reads still answer, with zero data
  assign b_hit = (tr_b_row < 32'(d_eff)) && (tr_b_col < 32'(T));

  epu_sram_1r1w #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_b (
    .clk   (clk),
    .we    (vld_p0),
    .waddr (addr_of(d_p0, t_p0)),
    .wdata (a_q),
    .wmask ({BYTE_W{1'b1}}),
    .re    (tr_b_re && b_hit),
    .raddr (addr_of(tr_b_row[D_W-1:0], tr_b_col[T_W-1:0])),
    .rdata (b_q)
  );

  assign tr_b_rdata  = b_hit_p0 ? b_q : '0;
  assign tr_b_rvalid = rvalid_p0;
  assign tr_busy     = (state != TR_IDLE);
  assign tr_done     = (state == TR_DONE);

endmodule

// File: tb/tb_kt_transpose_engine.sv
// Directed bench for kt_transpose_engine: load K, run transposes, read K^T
// and check timing, clamping, masking, start handling and reset behaviour.
module tb_kt_transpose_engine;

  logic        clk;
  logic        rst_n;
  logic [15:0] D_len;
  logic        k_we;
  logic [2:0]  k_t;
  logic [9:0]  k_d;
  logic [31:0] k_wdata;
  logic [3:0]  k_wmask;
  logic        tr_start;
  logic        tr_busy;
  logic        tr_done;
  logic        tr_b_re;
  logic [31:0] tr_b_row;
  logic [31:0] tr_b_col;
  logic [31:0] tr_b_rdata;
  logic        tr_b_rvalid;

  int errors = 0;
  int checks = 0;

  kt_transpose_engine #(.T(8), .DMAX(1024), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .D_len       (D_len),
    .k_we        (k_we),
    .k_t         (k_t),
    .k_d         (k_d),
    .k_wdata     (k_wdata),
    .k_wmask     (k_wmask),
    .tr_start    (tr_start),
    .tr_busy     (tr_busy),
    .tr_done     (tr_done),
    .tr_b_re     (tr_b_re),
    .tr_b_row    (tr_b_row),
    .tr_b_col    (tr_b_col),
    .tr_b_rdata  (tr_b_rdata),
    .tr_b_rvalid (tr_b_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic k_write(input int t, input int d, input logic [31:0] data,
                         input logic [3:0] mask);
    @(negedge clk);
    k_we = 1'b1; k_t = 3'(t); k_d = 10'(d); k_wdata = data; k_wmask = mask;
    @(negedge clk);
    k_we = 1'b0;
  endtask

  task automatic b_read(input int row, input int col, output logic [31:0] data,
                        output logic vld);
    @(negedge clk);
    tr_b_re = 1'b1; tr_b_row = row; tr_b_col = col;
    @(negedge clk);
    data = tr_b_rdata; vld = tr_b_rvalid;
    tr_b_re = 1'b0;
  endtask

  // Pulses tr_start, counts busy cycles before tr_done and done pulses seen.
  task automatic run_tr(input logic [15:0] dlen, input bit mid_we,
                        output int busy_n, output int done_n);
    @(negedge clk);
    D_len = dlen; tr_start = 1'b1;
    @(negedge clk);
    tr_start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 20000; i++) begin
      if (mid_we && i == 3) begin
        k_we = 1'b1; k_t = 3'd2; k_d = 10'd3; k_wdata = 32'hDEADBEEF; k_wmask = 4'hF;
      end
      if (i == 4) k_we = 1'b0;
      if (tr_done) begin
        done_n++;
        break;
      end
      if (tr_busy) busy_n++;
      else break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tr_done) done_n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tr_busy); end
    checks++; if (tr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tr_done); end
    checks++; if (tr_b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", tr_b_rvalid); end
    checks++; if (tr_b_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", tr_b_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", tr_busy); end
  endtask

  task automatic test_basic();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    for (int t = 0; t < 8; t++)
      for (int d = 0; d < 4; d++) k_write(t, d, 32'(256 * t + d), 4'hF);
    run_tr(16'd4, 1'b0, busy_n, done_n);
    checks++; if (busy_n !== 34) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 34", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_n); end
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got %b want 0", tr_busy); end
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 8; t++) begin
        b_read(d, t, data, vld);
        checks++;
        if (data !== 32'(256 * t + d)) begin
          errors++; $display("FAIL basic_read(%0d,%0d): got %h want %h", d, t, data, 32'(256 * t + d));
        end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL basic_rvalid(%0d,%0d): got %b want 1", d, t, vld); end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tr_b_re = 1'b1; tr_b_row = i; tr_b_col = 7 - i;
      @(negedge clk);
      checks++;
      if (tr_b_rdata !== 32'(256 * (7 - i) + i)) begin
        errors++; $display("FAIL b2b_read%0d: got %h want %h", i, tr_b_rdata, 32'(256 * (7 - i) + i));
      end
      checks++; if (tr_b_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d: got %b want 1", i, tr_b_rvalid); end
    end
    tr_b_re = 1'b0;
    @(negedge clk);
    checks++; if (tr_b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_drop: got %b want 0", tr_b_rvalid); end
    checks++; if (tr_b_rdata !== 32'h403) begin errors++; $display("FAIL b2b_rdata_hold: got %h want 00000403", tr_b_rdata); end
  endtask

  task automatic test_mask_write();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    k_write(1, 0, 32'hFFFFFFFF, 4'hF);
    k_write(1, 0, 32'h11223344, 4'b0101);
    k_write(1, 0, 32'h00000000, 4'b0000);
    run_tr(16'd1, 1'b0, busy_n, done_n);
    checks++; if (busy_n !== 10) begin errors++; $display("FAIL mask_busy_cycles: got %0d want 10", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL mask_done_pulses: got %0d want 1", done_n); end
    b_read(0, 1, data, vld);
    checks++; if (data !== 32'hFF22FF44) begin errors++; $display("FAIL mask_merge: got %h want ff22ff44", data); end
    b_read(0, 0, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL mask_neighbour: got %h want 0", data); end
    b_read(1, 0, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL mask_row_oor_data: got %h want 0", data); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL mask_row_oor_rvalid: got %b want 1", vld); end
    k_write(1, 0, 32'h100, 4'hF);
  endtask

  task automatic test_write_during_run();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    run_tr(16'd4, 1'b1, busy_n, done_n);
    checks++; if (busy_n !== 34) begin errors++; $display("FAIL wrun_busy_cycles: got %0d want 34", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL wrun_done_pulses: got %0d want 1", done_n); end
    b_read(3, 2, data, vld);
    checks++; if (data !== 32'h203) begin errors++; $display("FAIL wrun_dropped: got %h want 00000203", data); end
  endtask

  task automatic test_start_retrigger();
    int b1, b2, d1, d2;
    logic [31:0] data;
    logic vld;
    @(negedge clk);
    D_len = 16'd1; tr_start = 1'b1;
    @(negedge clk);
    b1 = 0; d1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 2) D_len = 16'd3;
      if (tr_done) begin d1++; break; end
      if (tr_busy) b1++;
      else break;
      @(negedge clk);
    end
    checks++; if (b1 !== 10) begin errors++; $display("FAIL retrig_first_busy: got %0d want 10", b1); end
    checks++; if (d1 !== 1) begin errors++; $display("FAIL retrig_first_done: got %0d want 1", d1); end
    @(negedge clk);
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL retrig_idle_gap: got %b want 0", tr_busy); end
    @(negedge clk);
    checks++; if (tr_busy !== 1'b1) begin errors++; $display("FAIL retrig_restart: got %b want 1", tr_busy); end
    tr_start = 1'b0;
    b2 = 0; d2 = 0;
    for (int i = 0; i < 200; i++) begin
      if (tr_done) begin d2++; break; end
      if (tr_busy) b2++;
      else break;
      @(negedge clk);
    end
    checks++; if (b2 !== 26) begin errors++; $display("FAIL retrig_second_busy: got %0d want 26", b2); end
    checks++; if (d2 !== 1) begin errors++; $display("FAIL retrig_second_done: got %0d want 1", d2); end
    b_read(2, 5, data, vld);
    checks++; if (data !== 32'h502) begin errors++; $display("FAIL retrig_read: got %h want 00000502", data); end
    b_read(3, 0, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL retrig_row_oor: got %h want 0", data); end
  endtask

  task automatic test_clamp();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    k_write(7, 1023, 32'h7A5A03FF, 4'hF);
    run_tr(16'd2000, 1'b0, busy_n, done_n);
    checks++; if (busy_n !== 8194) begin errors++; $display("FAIL clamp_busy_cycles: got %0d want 8194", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL clamp_done_pulses: got %0d want 1", done_n); end
    b_read(1023, 7, data, vld);
    checks++; if (data !== 32'h7A5A03FF) begin errors++; $display("FAIL clamp_last: got %h want 7a5a03ff", data); end
    b_read(1024, 0, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL clamp_oor_data: got %h want 0", data); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL clamp_oor_rvalid: got %b want 1", vld); end
    b_read(0, 8, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL clamp_col_oor: got %h want 0", data); end
  endtask

  task automatic test_zero_len();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    run_tr(16'd0, 1'b0, busy_n, done_n);
    checks++; if (busy_n !== 0) begin errors++; $display("FAIL zero_busy_before_done: got %0d want 0", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", done_n); end
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL zero_idle_after: got %b want 0", tr_busy); end
    b_read(0, 0, data, vld);
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL zero_read_data: got %h want 0", data); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL zero_read_rvalid: got %b want 1", vld); end
  endtask

  task automatic test_reset_midrun();
    int busy_n, done_n;
    logic [31:0] data;
    logic vld;
    k_write(3, 2, 32'h55AA0302, 4'hF);
    @(negedge clk);
    D_len = 16'd4; tr_start = 1'b1;
    @(negedge clk);
    tr_start = 1'b0;
    tr_b_re = 1'b1; tr_b_row = 1; tr_b_col = 2;
    @(negedge clk);
    tr_b_re = 1'b0;
    checks++; if (tr_b_rdata !== 32'h201) begin errors++; $display("FAIL rmid_read_in_run: got %h want 00000201", tr_b_rdata); end
    checks++; if (tr_b_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_rvalid_in_run: got %b want 1", tr_b_rvalid); end
    repeat (3) @(negedge clk);
    checks++; if (tr_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", tr_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tr_busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy: got %b want 0", tr_busy); end
    checks++; if (tr_done !== 1'b0) begin errors++; $display("FAIL rmid_async_done: got %b want 0", tr_done); end
    checks++; if (tr_b_rdata !== 32'h0) begin errors++; $display("FAIL rmid_async_rdata: got %h want 0", tr_b_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    run_tr(16'd4, 1'b0, busy_n, done_n);
    checks++; if (busy_n !== 34) begin errors++; $display("FAIL rmid_busy_cycles: got %0d want 34", busy_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL rmid_done_pulses: got %0d want 1", done_n); end
    b_read(2, 3, data, vld);
    checks++; if (data !== 32'h55AA0302) begin errors++; $display("FAIL rmid_new_data: got %h want 55aa0302", data); end
    b_read(1, 6, data, vld);
    checks++; if (data !== 32'h601) begin errors++; $display("FAIL rmid_old_data: got %h want 00000601", data); end
  endtask

  initial begin
    rst_n = 1'b0; D_len = '0; k_we = 1'b0; k_t = '0; k_d = '0;
    k_wdata = '0; k_wmask = '0; tr_start = 1'b0; tr_b_re = 1'b0;
    tr_b_row = '0; tr_b_col = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_mask_write();
    test_write_during_run();
    test_start_retrigger();
    test_clamp();
    test_zero_len();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
